// File: rtl/bp_cfg_link_endpoint_pkg.sv
// Shared definitions for the config-link endpoint: register offsets, forwarding windows,
// FSM state and forward-select encodings, and the offset decoder.
package bp_common_cfg_link_pkg;

  localparam logic [15:0] cfg_reg_reset_gp       = 16'h0001;
  localparam logic [15:0] cfg_reg_freeze_gp      = 16'h0002;
  localparam logic [15:0] cfg_reg_core_id_gp     = 16'h0003;
  localparam logic [15:0] cfg_reg_icache_id_gp   = 16'h0021;
  localparam logic [15:0] cfg_reg_icache_mode_gp = 16'h0022;
  localparam logic [15:0] cfg_reg_npc_gp         = 16'h0040;
  localparam logic [15:0] cfg_reg_dcache_id_gp   = 16'h0041;
  localparam logic [15:0] cfg_reg_dcache_mode_gp = 16'h0042;
  localparam logic [15:0] cfg_reg_cce_id_gp      = 16'h0080;
  localparam logic [15:0] cfg_reg_cce_mode_gp    = 16'h0081;
  localparam logic [15:0] cfg_reg_num_lce_gp     = 16'h0082;

  localparam logic [15:0] cfg_irf_lo_gp   = 16'h0050;
  localparam logic [15:0] cfg_irf_hi_gp   = 16'h006f;
  localparam logic [15:0] cfg_ucode_lo_gp = 16'h8000;
  localparam logic [15:0] cfg_ucode_hi_gp = 16'h8fff;

  typedef enum logic [1:0] {IDLE, FWD_REQ, FWD_WAIT, RESP} bp_cfg_link_state_e;

  typedef enum logic {e_fwd_irf = 1'b0, e_fwd_ucode = 1'b1} bp_cfg_fwd_sel_e;

  typedef enum logic [3:0] {
    e_reg_none,
    e_reg_reset,
    e_reg_freeze,
    e_reg_icache_mode,
    e_reg_npc,
    e_reg_dcache_mode,
    e_reg_cce_mode,
    e_reg_id,
    e_reg_num_lce
  } bp_cfg_reg_e;

  function automatic bp_cfg_reg_e cfg_decode_reg(input logic [15:0] off);
    bp_cfg_reg_e r;
    r = e_reg_none;
    case (off)
      cfg_reg_reset_gp:       r = e_reg_reset;
      cfg_reg_freeze_gp:      r = e_reg_freeze;
      cfg_reg_icache_mode_gp: r = e_reg_icache_mode;
      cfg_reg_npc_gp:         r = e_reg_npc;
      cfg_reg_dcache_mode_gp: r = e_reg_dcache_mode;
      cfg_reg_cce_mode_gp:    r = e_reg_cce_mode;
      cfg_reg_core_id_gp,
      cfg_reg_icache_id_gp,
      cfg_reg_dcache_id_gp,
      cfg_reg_cce_id_gp:      r = e_reg_id;
      cfg_reg_num_lce_gp:     r = e_reg_num_lce;
      default:                r = e_reg_none;
    endcase
    return r;
  endfunction

  function automatic logic cfg_reg_is_rw(input bp_cfg_reg_e r);
    return (r inside {e_reg_reset, e_reg_freeze, e_reg_icache_mode,
                      e_reg_npc, e_reg_dcache_mode, e_reg_cce_mode});
  endfunction

endpackage

// File: rtl/bp_cfg_link_endpoint_if.sv
// Command/response and forward-window handshake bundle of the config-link endpoint.
// Signal suffixes are from the endpoint's point of view.
interface bp_cfg_link_endpoint_if #(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 24
);
  logic                    cmd_v_i;
  logic                    cmd_ready_o;
  logic                    cmd_w_i;
  logic [addr_width_p-1:0] cmd_addr_i;
  logic [data_width_p-1:0] cmd_data_i;

  logic                    resp_v_o;
  logic [data_width_p-1:0] resp_data_o;
  logic                    resp_err_o;
  logic                    resp_yumi_i;

  logic                    fwd_v_o;
  logic                    fwd_ready_i;
  logic                    fwd_w_o;
  logic                    fwd_sel_o;
  logic [3:0]              fwd_core_o;
  logic [11:0]             fwd_addr_o;
  logic [data_width_p-1:0] fwd_data_o;
  logic                    fwd_resp_v_i;
  logic [data_width_p-1:0] fwd_resp_data_i;

  modport slave (
    input  cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
           fwd_ready_i, fwd_resp_v_i, fwd_resp_data_i,
    output cmd_ready_o, resp_v_o, resp_data_o, resp_err_o,
           fwd_v_o, fwd_w_o, fwd_sel_o, fwd_core_o, fwd_addr_o, fwd_data_o
  );

  modport master (
    output cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
           fwd_ready_i, fwd_resp_v_i, fwd_resp_data_i,
    input  cmd_ready_o, resp_v_o, resp_data_o, resp_err_o,
           fwd_v_o, fwd_w_o, fwd_sel_o, fwd_core_o, fwd_addr_o, fwd_data_o
  );
endinterface

// File: rtl/bp_cfg_link_endpoint_core_regs.sv
// Control register bank for one core: write-enabled RW fields plus a read mux that
// also serves the read-only id / num_lce values.
module bp_cfg_link_core_regs
  import bp_common_cfg_link_pkg::*;
#(
  parameter int          data_width_p  = 64,
  parameter int          vaddr_width_p = 39,
  parameter int          num_core_p    = 2,
  parameter int          core_id_p     = 0,
  parameter logic [63:0] npc_reset_p   = 64'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     we_i,
  input  bp_cfg_reg_e              reg_i,
  input  logic [data_width_p-1:0]  wdata_i,
  output logic [data_width_p-1:0]  rdata_o,
  output logic                     core_reset_o,
  output logic                     freeze_o,
  output logic [vaddr_width_p-1:0] npc_o,
  output logic [1:0]               icache_mode_o,
  output logic [1:0]               dcache_mode_o,
  output logic                     cce_mode_o
);

  logic                     core_reset_reg;
  logic                     freeze_reg;
  logic [vaddr_width_p-1:0] npc_reg;
  logic [1:0]               icache_mode_reg;
  logic [1:0]               dcache_mode_reg;
  logic                     cce_mode_reg;

  // Only the low field width of the write data is kept.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      core_reset_reg  <= 1'b1;
      freeze_reg      <= 1'b1;
      npc_reg         <= npc_reset_p[vaddr_width_p-1:0];
      icache_mode_reg <= 2'b00;
      dcache_mode_reg <= 2'b00;
      cce_mode_reg    <= 1'b0;
    end else if (we_i) begin
      case (reg_i)
        e_reg_reset:       core_reset_reg  <= wdata_i[0];
        e_reg_freeze:      freeze_reg      <= wdata_i[0];
        e_reg_npc:         npc_reg         <= wdata_i[vaddr_width_p-1:0];
        e_reg_icache_mode: icache_mode_reg <= wdata_i[1:0];
        e_reg_dcache_mode: dcache_mode_reg <= wdata_i[1:0];
        e_reg_cce_mode:    cce_mode_reg    <= wdata_i[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_i)
      e_reg_reset:       rdata_o[0]                 = core_reset_reg;
      e_reg_freeze:      rdata_o[0]                 = freeze_reg;
      e_reg_npc:         rdata_o[vaddr_width_p-1:0] = npc_reg;
      e_reg_icache_mode: rdata_o[1:0]               = icache_mode_reg;
      e_reg_dcache_mode: rdata_o[1:0]               = dcache_mode_reg;
      e_reg_cce_mode:    rdata_o[0]                 = cce_mode_reg;
      e_reg_id:          rdata_o                    = data_width_p'(core_id_p);
      e_reg_num_lce:     rdata_o                    = data_width_p'(2 * num_core_p);
      default: ;
    endcase
  end

  assign core_reset_o  = core_reset_reg;
  assign freeze_o      = freeze_reg;
  assign npc_o         = npc_reg;
  assign icache_mode_o = icache_mode_reg;
  assign dcache_mode_o = dcache_mode_reg;
  assign cce_mode_o    = cce_mode_reg;

endmodule

// File: rtl/bp_cfg_link_endpoint.sv
// Config-link slave: decodes one outstanding cmd at a time, services per-core control
// registers locally and forwards IRF / CCE-ucode window accesses to an external port.
module bp_cfg_link_endpoint
  import bp_common_cfg_link_pkg::*;
#(
  parameter int          num_core_p    = 2,
  parameter int          data_width_p  = 64,
  parameter int          addr_width_p  = 24,
  parameter int          vaddr_width_p = 39,
  parameter logic [63:0] npc_reset_p   = 64'h8000_0000
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  bp_cfg_link_endpoint_if.slave               link,
  output logic [num_core_p-1:0]               core_reset_o,
  output logic [num_core_p-1:0]               freeze_o,
  output logic [num_core_p*vaddr_width_p-1:0] npc_o,
  output logic [num_core_p*2-1:0]             icache_mode_o,
  output logic [num_core_p*2-1:0]             dcache_mode_o,
  output logic [num_core_p-1:0]               cce_mode_o
);

  localparam int core_field_lp = addr_width_p - 16;
  localparam logic [core_field_lp-1:0] num_core_lp = core_field_lp'(num_core_p);

  bp_cfg_link_state_e state_reg, state_next;

  logic [data_width_p-1:0] resp_data_reg;
  logic                    resp_err_reg;
  logic                    fwd_w_reg;
  bp_cfg_fwd_sel_e         fwd_sel_reg;
  logic [3:0]              fwd_core_reg;
  logic [11:0]             fwd_addr_reg;
  logic [data_width_p-1:0] fwd_data_reg;

  logic [core_field_lp-1:0] cmd_core;
  logic [15:0]              cmd_off;
  bp_cfg_reg_e              cmd_reg;
  logic                     core_ok;
  logic                     in_irf;
  logic                     in_ucode;
  logic                     is_fwd;
  logic                     local_ok;
  logic                     cmd_accept;
  logic                     fwd_done;
  logic [11:0]              fwd_addr_next;
  logic [data_width_p-1:0]  sel_rdata;
  logic [num_core_p-1:0]    core_we;
  logic [data_width_p-1:0]  core_rdata [num_core_p];

  always_comb begin
    cmd_core      = link.cmd_addr_i[addr_width_p-1:16];
    cmd_off       = link.cmd_addr_i[15:0];
    cmd_reg       = cfg_decode_reg(cmd_off);
    core_ok       = (cmd_core < num_core_lp);
    in_irf        = (cmd_off >= cfg_irf_lo_gp) && (cmd_off <= cfg_irf_hi_gp);
    in_ucode      = (cmd_off >= cfg_ucode_lo_gp) && (cmd_off <= cfg_ucode_hi_gp);
    is_fwd        = core_ok && (in_irf || in_ucode);
    local_ok      = core_ok && (cmd_reg != e_reg_none)
                    && !(link.cmd_w_i && !cfg_reg_is_rw(cmd_reg));
    cmd_accept    = link.cmd_v_i && (state_reg == IDLE);
    // Ucode window base is 4K-aligned, so its low 12 bits are already the offset.
    fwd_addr_next = in_ucode ? cmd_off[11:0] : (cmd_off[11:0] - cfg_irf_lo_gp[11:0]);
    fwd_done      = ((state_reg == FWD_REQ) && link.fwd_ready_i && link.fwd_resp_v_i)
                    || ((state_reg == FWD_WAIT) && link.fwd_resp_v_i);
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < num_core_p; i++) begin
      if (cmd_core == core_field_lp'(i)) sel_rdata = core_rdata[i];
    end
  end

  for (genvar gi = 0; gi < num_core_p; gi++) begin : g_core
    assign core_we[gi] = cmd_accept && link.cmd_w_i && local_ok
                         && (cmd_core == core_field_lp'(gi));

    bp_cfg_link_core_regs #(
      .data_width_p (data_width_p),
      .vaddr_width_p(vaddr_width_p),
      .num_core_p   (num_core_p),
      .core_id_p    (gi),
      .npc_reset_p  (npc_reset_p)
    ) u_regs (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .we_i         (core_we[gi]),
      .reg_i        (cmd_reg),
      .wdata_i      (link.cmd_data_i),
      .rdata_o      (core_rdata[gi]),
      .core_reset_o (core_reset_o[gi]),
      .freeze_o     (freeze_o[gi]),
      .npc_o        (npc_o[gi*vaddr_width_p +: vaddr_width_p]),
      .icache_mode_o(icache_mode_o[gi*2 +: 2]),
      .dcache_mode_o(dcache_mode_o[gi*2 +: 2]),
      .cce_mode_o   (cce_mode_o[gi])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (link.cmd_v_i) state_next = is_fwd ? FWD_REQ : RESP;
      end
      FWD_REQ: begin
        if (link.fwd_ready_i) state_next = link.fwd_resp_v_i ? RESP : FWD_WAIT;
      end
      FWD_WAIT: begin
        if (link.fwd_resp_v_i) state_next = RESP;
      end
      RESP: begin
        if (link.resp_yumi_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response and forward payloads are frozen at accept; only a forwarded read updates data later.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
      fwd_w_reg     <= 1'b0;
      fwd_sel_reg   <= e_fwd_irf;
      fwd_core_reg  <= 4'd0;
      fwd_addr_reg  <= 12'd0;
      fwd_data_reg  <= '0;
    end else if (cmd_accept) begin
      resp_err_reg  <= !is_fwd && !local_ok;
      resp_data_reg <= (!link.cmd_w_i && local_ok) ? sel_rdata : '0;
      fwd_w_reg     <= link.cmd_w_i;
      fwd_sel_reg   <= in_ucode ? e_fwd_ucode : e_fwd_irf;
      fwd_core_reg  <= cmd_core[3:0];
      fwd_addr_reg  <= fwd_addr_next;
      fwd_data_reg  <= link.cmd_data_i;
    end else if (fwd_done && !fwd_w_reg) begin
      resp_data_reg <= link.fwd_resp_data_i;
    end
  end

  assign link.cmd_ready_o = (state_reg == IDLE);
  assign link.resp_v_o    = (state_reg == RESP);
  assign link.resp_data_o = resp_data_reg;
  assign link.resp_err_o  = resp_err_reg;
  assign link.fwd_v_o     = (state_reg == FWD_REQ);
  assign link.fwd_w_o     = fwd_w_reg;
  assign link.fwd_sel_o   = fwd_sel_reg;
  assign link.fwd_core_o  = fwd_core_reg;
  assign link.fwd_addr_o  = fwd_addr_reg;
  assign link.fwd_data_o  = fwd_data_reg;

endmodule
